// File: rtl/logo_sprite_display_pkg.sv
// Shared types for the logo sprite overlay.
// Holds the animation state encoding, mode encoding and colour width.
package logo_sprite_display_pkg;

   localparam int COLOR_W = 12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SLIDE = 2'd1,
      ST_HOLD  = 2'd2,
      ST_BLINK = 2'd3
   } anim_state_e;

   typedef enum logic [1:0] {
      MODE_STATIC = 2'd0,
      MODE_SLIDE  = 2'd1,
      MODE_BLINK  = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_e;

endpackage

// File: rtl/logo_sprite_display_anim_ctrl.sv
// Logo animation controller: slide-in / blink FSM.
// Ports: clk, reset_n, frame_tick, start, mode in; ypos, visible, anim_done out.
module logo_anim_ctrl
   import logo_sprite_display_pkg::*;
#(
   parameter int Y_HOME       = 64,
   parameter int Y_START      = 0,
   parameter int SLIDE_STEP   = 2,
   parameter int BLINK_FRAMES = 32
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       frame_tick,
   input  logic       start,
   input  logic [1:0] mode,
   output logic [9:0] ypos,
   output logic       visible,
   output logic       anim_done
);

   localparam int CNT_W = (BLINK_FRAMES > 1) ?
                          $clog2(BLINK_FRAMES) : 1;

   anim_state_e state_q, state_d;
   logic [9:0] ypos_q, ypos_d;
   logic vis_q, vis_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [10:0] step_sum;

   assign step_sum = {1'b0, ypos_q} + 11'(SLIDE_STEP);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         ypos_q  <= 10'(Y_HOME);
         vis_q   <= 1'b1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ypos_q  <= ypos_d;
         vis_q   <= vis_d;
         cnt_q   <= cnt_d;
      end
   end

   // start has priority over frame_tick so a restart never also steps
   always_comb begin
      state_d = state_q;
      ypos_d  = ypos_q;
      vis_d   = vis_q;
      cnt_d   = cnt_q;
      if (start) begin
         vis_d  = 1'b1;
         cnt_d  = '0;
         ypos_d = 10'(Y_HOME);
         case (mode_e'(mode))
            MODE_SLIDE: begin
               state_d = ST_SLIDE;
               ypos_d  = 10'(Y_START);
            end
            MODE_BLINK: state_d = ST_BLINK;
            default:    state_d = ST_HOLD;
         endcase
      end else if (frame_tick) begin
         case (state_q)
            ST_SLIDE: begin
               if (step_sum >= 11'(Y_HOME)) begin
                  ypos_d  = 10'(Y_HOME);
                  state_d = ST_HOLD;
               end else begin
                  ypos_d = step_sum[9:0];
               end
            end
            ST_BLINK: begin
               if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                  cnt_d = '0;
                  vis_d = ~vis_q;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign ypos      = ypos_q;
   assign visible   = vis_q;
   assign anim_done = (state_q == ST_HOLD);

endmodule

// File: rtl/logo_sprite_display.sv
// Logo sprite overlay: ROM addressing, hit test and latency alignment.
// Ports: clk, reset_n, x, y, frame_tick, mode, start, rom_data in;
// rom_row, rom_col, rgb_out, logo_on, anim_done out.
module logo_sprite_display
   import logo_sprite_display_pkg::*;
#(
   parameter int          LOGO_W       = 368,
   parameter int          LOGO_H       = 35,
   parameter int          X_POS        = 136,
   parameter int          Y_HOME       = 64,
   parameter int          Y_START      = 0,
   parameter int          SLIDE_STEP   = 2,
   parameter int          BLINK_FRAMES = 32,
   parameter logic [11:0] KEY_RGB      = 12'h6DE,
   parameter int          ROM_LAT      = 1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [9:0]                 x,
   input  logic [9:0]                 y,
   input  logic                       frame_tick,
   input  logic [1:0]                 mode,
   input  logic                       start,
   output logic [$clog2(LOGO_H)-1:0]  rom_row,
   output logic [$clog2(LOGO_W)-1:0]  rom_col,
   input  logic [COLOR_W-1:0]         rom_data,
   output logic [COLOR_W-1:0]         rgb_out,
   output logic                       logo_on,
   output logic                       anim_done
);

   localparam int ROW_W = $clog2(LOGO_H);
   localparam int COL_W = $clog2(LOGO_W);

   logic [9:0] ypos;
   logic visible;
   logic [9:0] row_full, col_full;
   logic [10:0] x_w, y_w, yp_w;
   logic hit;
   logic [ROM_LAT-1:0] hit_q, hit_d;

   logo_anim_ctrl #(
      .Y_HOME       (Y_HOME),
      .Y_START      (Y_START),
      .SLIDE_STEP   (SLIDE_STEP),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_ctrl (
      .clk        (clk),
      .reset_n    (reset_n),
      .frame_tick (frame_tick),
      .start      (start),
      .mode       (mode),
      .ypos       (ypos),
      .visible    (visible),
      .anim_done  (anim_done)
   );

   assign row_full = y - ypos;
   assign col_full = x - 10'(X_POS);
   assign rom_row  = row_full[ROW_W-1:0];
   assign rom_col  = col_full[COL_W-1:0];

   // widen to 11 bits so X_POS+LOGO_W and ypos+LOGO_H cannot wrap
   assign x_w  = {1'b0, x};
   assign y_w  = {1'b0, y};
   assign yp_w = {1'b0, ypos};

   assign hit = (x_w >= 11'(X_POS)) &&
                (x_w < 11'(X_POS + LOGO_W)) &&
                (y_w >= yp_w) &&
                (y_w < yp_w + 11'(LOGO_H));

   // hit travels alongside the ROM read so both land together
   always_comb begin
      hit_d    = hit_q;
      hit_d[0] = hit;
      for (int i = 1; i < ROM_LAT; i++) begin
         hit_d[i] = hit_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hit_q <= '0;
      end else begin
         hit_q <= hit_d;
      end
   end

   assign logo_on = hit_q[ROM_LAT-1] && visible &&
                    (rom_data != KEY_RGB);
   assign rgb_out = logo_on ? rom_data : '0;

endmodule

// File: tb/tb_logo_sprite_display.sv
// Randomized check of logo_sprite_display against a frame-level model.
// Two instances: defaults, and ROM_LAT=3 / BLINK_FRAMES=4 / Y_START=Y_HOME.
module tb_logo_sprite_display;

   localparam logic [11:0] KEY = 12'h6DE;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [9:0] x = '0, y = '0;
   logic frame_tick = 1'b0, start = 1'b0;
   logic [1:0] mode = '0;

   logic [5:0] row0, row1;
   logic [8:0] col0, col1;
   logic [11:0] rd0, rd1a, rd1b, rd1c;
   logic [11:0] rgb0, rgb1;
   logic lo0, lo1, done0, done1;

   logic [11:0] rom [64][512];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // external ROM models with the instance's read latency
   always @(posedge clk) begin
      rd0  <= rom[row0][col0];
      rd1a <= rom[row1][col1];
      rd1b <= rd1a;
      rd1c <= rd1b;
   end

   logo_sprite_display #(.ROM_LAT(1)) dut0 (
      .clk(clk), .reset_n(reset_n), .x(x), .y(y),
      .frame_tick(frame_tick), .mode(mode), .start(start),
      .rom_row(row0), .rom_col(col0), .rom_data(rd0),
      .rgb_out(rgb0), .logo_on(lo0), .anim_done(done0)
   );

   logo_sprite_display #(
      .ROM_LAT(3), .BLINK_FRAMES(4), .Y_START(64)
   ) dut1 (
      .clk(clk), .reset_n(reset_n), .x(x), .y(y),
      .frame_tick(frame_tick), .mode(mode), .start(start),
      .rom_row(row1), .rom_col(col1), .rom_data(rd1c),
      .rgb_out(rgb1), .logo_on(lo1), .anim_done(done1)
   );

   // ---- reference model: animation as (kind, ticks since start) ----
   // kind: 0 idle, 1 slide, 2 blink, 3 hold
   int LATP [2] = '{1, 3};
   int BFP  [2] = '{32, 4};
   int YSP  [2] = '{0, 64};
   int kind [2];
   int ticks[2];

   typedef struct {
      bit          hit;
      logic [11:0] pix;
   } exp_t;
   exp_t hq0[$];
   exp_t hq1[$];

   function automatic int m_ypos(int k);
      int v;
      if (kind[k] != 1) return 64;
      v = YSP[k] + 2 * ticks[k];
      return (v > 64) ? 64 : v;
   endfunction

   function automatic bit m_vis(int k);
      if (kind[k] != 2) return 1'b1;
      return ((ticks[k] / BFP[k]) % 2) == 0;
   endfunction

   function automatic void m_update(int k, bit ft, bit st, int md);
      if (st) begin
         ticks[k] = 0;
         kind[k] = (md == 1) ? 1 : (md == 2) ? 2 : 3;
      end else if (ft) begin
         if (kind[k] == 1) begin
            ticks[k]++;
            if (YSP[k] + 2 * ticks[k] >= 64) kind[k] = 3;
         end else if (kind[k] == 2) begin
            ticks[k]++;
         end
      end
   endfunction

   function automatic exp_t m_pixel(int k, int xi, int yi);
      exp_t e;
      int yp;
      yp = m_ypos(k);
      e.hit = (xi >= 136) && (xi < 504) &&
              (yi >= yp) && (yi < yp + 35);
      e.pix = e.hit ? rom[yi - yp][xi - 136] : 12'h000;
      return e;
   endfunction

   task automatic chk(input string tag, input int k,
                      input logic [11:0] obs,
                      input logic [11:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d observed=%h expected=%h t=%0t",
                tag, k, obs, exp, $time);
      end
   endtask

   task automatic check_out(int k, exp_t e);
      logic on;
      logic [11:0] rgb;
      on  = e.hit && m_vis(k) && (e.pix != KEY);
      rgb = on ? e.pix : 12'h000;
      if (k == 0) begin
         chk("logo_on", 0, {11'b0, lo0}, {11'b0, on});
         chk("rgb_out", 0, rgb0, rgb);
         chk("anim_done", 0, {11'b0, done0},
             {11'b0, kind[0] == 3});
      end else begin
         chk("logo_on", 1, {11'b0, lo1}, {11'b0, on});
         chk("rgb_out", 1, rgb1, rgb);
         chk("anim_done", 1, {11'b0, done1},
             {11'b0, kind[1] == 3});
      end
   endtask

   // one pixel clock: present inputs mid-cycle, check after the edge
   task automatic step(input int xi, input int yi,
                       input bit ft, input bit st, input int md);
      exp_t e;
      x = 10'(xi);
      y = 10'(yi);
      frame_tick = ft;
      start = st;
      mode = 2'(md);
      hq0.push_back(m_pixel(0, xi, yi));
      hq1.push_back(m_pixel(1, xi, yi));
      @(posedge clk);
      #5;
      m_update(0, ft, st, md);
      m_update(1, ft, st, md);
      e = hq0.pop_front();
      check_out(0, e);
      e = hq1.pop_front();
      check_out(1, e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      step(0, 0, 1, 0, 0);
   endtask

   task automatic do_reset();
      exp_t z;
      reset_n = 1'b0;
      frame_tick = 1'b0;
      start = 1'b0;
      #1;
      chk("rst_logo_on", 0, {11'b0, lo0}, 12'h000);
      chk("rst_logo_on", 1, {11'b0, lo1}, 12'h000);
      chk("rst_rgb", 1, rgb1, 12'h000);
      repeat (2) @(posedge clk);
      #5;
      chk("rst_done", 0, {11'b0, done0}, 12'h000);
      chk("rst_done", 1, {11'b0, done1}, 12'h000);
      chk("rst_rgb", 0, rgb0, 12'h000);
      reset_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         kind[k] = 0;
         ticks[k] = 0;
      end
      hq0.delete();
      hq1.delete();
      z.hit = 1'b0;
      z.pix = 12'h000;
      for (int i = 1; i < LATP[0]; i++) hq0.push_back(z);
      for (int i = 1; i < LATP[1]; i++) hq1.push_back(z);
   endtask

   task automatic rand_steps(input int n, input int st_div);
      int md;
      for (int i = 0; i < n; i++) begin
         md = $urandom_range(0, 3);
         step($urandom_range(120, 520), $urandom_range(0, 110),
              $urandom_range(0, 3) == 0,
              $urandom_range(0, st_div - 1) == 0, md);
      end
   endtask

   task automatic probe_slide();
      int yp;
      yp = m_ypos(0);
      step(136, yp, 0, 0, 0);
      step($urandom_range(136, 503), yp + 34, 0, 0, 0);
      step(136, yp + 35, 0, 0, 0);
      if (yp > 0) step(137, yp - 1, 0, 0, 0);
   endtask

   initial begin
      int v;
      // columns near both edges are kept opaque for boundary probes
      for (int r = 0; r < 64; r++) begin
         for (int c = 0; c < 512; c++) begin
            v = $urandom_range(0, 4095);
            if (c >= 8 && c < 360 && $urandom_range(0, 4) == 0)
               v = 12'h6DE;
            else if (v == 12'h6DE)
               v = 12'h123;
            rom[r][c] = 12'(v);
         end
      end

      do_reset();

      // static pixel and key colour
      rom[0][0] = 12'hF00;
      step(136, 64, 0, 0, 0);
      chk("req042_on", 0, {11'b0, lo0}, 12'h001);
      chk("req042_rgb", 0, rgb0, 12'hF00);
      idle(3);
      rom[0][0] = KEY;
      step(136, 64, 0, 0, 0);
      chk("req042_key_on", 0, {11'b0, lo0}, 12'h000);
      chk("req042_key_rgb", 0, rgb0, 12'h000);
      idle(3);
      rom[0][0] = 12'hF00;

      // window boundaries
      step(135, 64, 0, 0, 0);
      step(504, 64, 0, 0, 0);
      step(136, 99, 0, 0, 0);
      step(503, 98, 0, 0, 0);
      chk("req043_corner", 0, {11'b0, lo0}, 12'h001);
      step(503, 64, 0, 0, 0);
      step(136, 63, 0, 0, 0);
      step(1023, 1023, 0, 0, 0);
      idle(3);

      rand_steps(100, 1000000);

      // static start goes straight to hold
      step(0, 0, 0, 1, 0);
      chk("hold_done", 0, {11'b0, done0}, 12'h001);

      // slide-in from row 0
      step(0, 0, 0, 1, 1);
      step(136, 0, 0, 0, 0);
      chk("slide_top", 0, {11'b0, lo0}, 12'h001);
      probe_slide();
      for (int t = 1; t <= 32; t++) begin
         tick();
         if (t == 1)
            chk("slide_eq_done", 1, {11'b0, done1}, 12'h001);
         if (t == 31)
            chk("slide_t31", 0, {11'b0, done0}, 12'h000);
         if (t == 32)
            chk("slide_t32", 0, {11'b0, done0}, 12'h001);
         probe_slide();
      end
      idle(3);

      // restart collides with a tick mid-slide
      step(0, 0, 0, 1, 1);
      for (int t = 0; t < 20; t++) tick();
      probe_slide();
      step(0, 0, 1, 1, 1);
      step(136, 0, 0, 0, 0);
      chk("restart_top", 0, {11'b0, lo0}, 12'h001);
      probe_slide();
      tick();
      tick();
      probe_slide();
      step(136, 4, 0, 0, 0);
      step(136, 64, 0, 0, 0);
      step(136, 5, 0, 0, 0);
      do_reset();
      step(136, 64, 0, 0, 0);
      chk("rst_home", 0, {11'b0, lo0}, 12'h001);
      step(136, 4, 0, 0, 0);
      tick();
      probe_slide();
      idle(3);

      // blink
      step(0, 0, 0, 1, 2);
      for (int t = 1; t <= 12; t++) begin
         tick();
         step(136, 64, 0, 0, 0);
         step(503, 98, 0, 0, 0);
         idle(3);
      end

      rand_steps(1500, 60);
      rand_steps(1500, 400);

      // reset while pixels are in flight
      step(0, 0, 0, 1, 0);
      step(136, 64, 0, 0, 0);
      step(137, 65, 0, 0, 0);
      step(138, 66, 0, 0, 0);
      do_reset();
      rand_steps(200, 100);
      idle(5);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/logo_sprite_display.md
LOGO_SPRITE_DISPLAY -- requirements
Module: logo_sprite_display

Interface
REQ-001 SHALL have parameter LOGO_W, default 368, logo width in pixels.
REQ-002 SHALL have parameter LOGO_H, default 35, logo height in pixels.
REQ-003 SHALL have parameter X_POS, default 136, fixed left column.
REQ-004 SHALL have parameter Y_HOME, default 64, final top row.
REQ-005 SHALL have parameter Y_START, default 0, slide-in starting top row (Y_START <= Y_HOME).
REQ-006 SHALL have parameter SLIDE_STEP, default 2, rows moved per frame during slide-in.
REQ-007 SHALL have parameter BLINK_FRAMES, default 32, frames per blink half-period.
REQ-008 SHALL have parameter KEY_RGB, default 12'h6DE, transparent colour.
REQ-009 SHALL have parameter ROM_LAT, default 1 (range 1-3), external ROM read latency in cycles.
REQ-010 clk  in  1  pixel clock, single clock domain.
REQ-011 reset_n  in  1  asynchronous, active-low reset.
REQ-012 x, y  in  10 each  current pixel coordinates from vga_sync.
REQ-013 frame_tick  in  1  one-cycle pulse once per frame, during vertical blanking.
REQ-014 mode  in  2  0 static, 1 slide-in, 2 blink, 3 reserved (treated as static).
REQ-015 start  in  1  one-cycle pulse that (re)starts the selected animation.
REQ-016 rom_row  out  clog2(LOGO_H)  ROM row address.
REQ-017 rom_col  out  clog2(LOGO_W)  ROM column address.
REQ-018 rom_data  in  12  ROM pixel, valid ROM_LAT cycles after its address.
REQ-019 rgb_out  out  12  logo pixel colour, 0 when logo_on is low.
REQ-020 logo_on  out  1  opaque logo pixel at the delayed coordinate.
REQ-021 anim_done  out  1  high while the animation state is HOLD.

Function
REQ-022 rom_row SHALL be y - ypos and rom_col SHALL be x - X_POS, combinational and truncated to port width.
REQ-023 hit SHALL be X_POS <= x < X_POS+LOGO_W and ypos <= y < ypos+LOGO_H, using 11-bit compares with no wrap.
REQ-024 hit SHALL be delayed ROM_LAT cycles through a shift pipeline aligned with rom_data.
REQ-025 logo_on SHALL equal hit_d AND visible AND (rom_data != KEY_RGB).
REQ-026 rgb_out SHALL equal rom_data when logo_on is high, otherwise 12'h000.
REQ-027 Output latency SHALL be exactly ROM_LAT cycles from x/y to rgb_out/logo_on.
REQ-028 FSM states SHALL be IDLE, SLIDE, HOLD and BLINK.
REQ-029 IDLE: ypos=Y_HOME, visible=1; on start: mode 1 -> SLIDE with ypos=Y_START; mode 2 -> BLINK with frame counter=0; other modes -> HOLD.
REQ-030 SLIDE: on each frame_tick, ypos = min(ypos+SLIDE_STEP, Y_HOME); when ypos reaches Y_HOME the FSM SHALL enter HOLD on that tick.
REQ-031 BLINK: on each frame_tick the counter increments; at BLINK_FRAMES-1 the counter wraps to 0 and visible toggles; BLINK persists until start.
REQ-032 HOLD: ypos=Y_HOME, visible=1; start SHALL re-enter the animation per REQ-029.
REQ-033 ypos, visible and the counter SHALL change only on a frame_tick or start edge, never mid-scan.
REQ-034 If start and frame_tick coincide, start SHALL win and no step or count SHALL occur that cycle.
REQ-035 start SHALL abort any animation in progress and restart it from its initial values.
REQ-036 mode SHALL be sampled only on start.
REQ-037 If Y_START == Y_HOME, slide-in SHALL complete on the first frame_tick.

Reset
REQ-038 On reset_n low: state=IDLE, ypos=Y_HOME, visible=1, counter=0, hit pipeline=0, logo_on=0, rgb_out=0, anim_done=0.
REQ-039 Reset mid-animation SHALL abandon it immediately, with no resumption after release.

Structure
REQ-040 Shared package SHALL hold the FSM state encoding, the mode encodings, and the colour width constant (12).
REQ-041 One sub-module, logo_anim_ctrl, SHALL own the FSM, ypos, visible, counter and anim_done; the top SHALL own addressing, hit and the latency pipeline.

Verification
REQ-042 mode 0, ROM_LAT=1, x=136, y=64, rom_data=12'hF00 -> next cycle logo_on=1, rgb_out=12'hF00; rom_data=KEY_RGB -> logo_on=0, rgb_out=0.
REQ-043 Boundary: x=135, x=504, y=99 -> logo_on=0; x=503, y=98 -> logo_on=1 for an opaque pixel.
REQ-044 mode 1 start: ypos=0, 32 frame_ticks -> ypos=64, anim_done rises on tick 32; pixel at y=0, x=136 is hit during the frames before the first tick.
REQ-045 mode 2 start, BLINK_FRAMES=4: visible is 0 after ticks 4-7 and 1 after ticks 8-11; logo_on is forced 0 while hidden.
REQ-046 start and frame_tick in the same cycle during SLIDE at ypos=40 -> ypos=0 and no step that cycle; reset_n low mid-slide -> ypos=64, state IDLE.
REQ-047 ROM_LAT=3: logo_on/rgb_out are aligned to x/y presented 3 cycles earlier, with the pipeline flushed to 0 after reset.
